// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential shift-and-add-3 (double dabble) binary-to-BCD converter for the
//   ALU result display path. A request loads the magnitude of i_data into a
//   binary shift register. One bit is then moved into the BCD accumulator per
//   cycle. After NB_DATA shifts the digits, the sign and a leading-zero digit
//   mask are registered together on the outputs. The outputs hold steady
//   between conversions, so the displays never show a partial value.
//
// Parameters
//   NB_DATA    width of the binary input and number of shift cycles
//   NB_DIGITS  BCD digits produced (10**NB_DIGITS must exceed 2**NB_DATA)
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous reset, active low
//   i_start     conversion request, honoured only while idle
//   i_signed    treat i_data as two's complement (sampled with i_start)
//   i_data      binary value (sampled with i_start)
//   o_busy      conversion in progress
//   o_done      one-cycle pulse when a new result appears on the outputs
//   o_bcd       BCD digits, digit k at [4k+3:4k], digit 0 = units
//   o_neg       result is negative
//   o_digit_en  digit k lit when it or any higher digit is nonzero; bit 0 always lit
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int NB_DATA   = 8,
  parameter int NB_DIGITS = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_signed,
  input  logic [NB_DATA-1:0]     i_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [4*NB_DIGITS-1:0] o_bcd,
  output logic                   o_neg,
  output logic [NB_DIGITS-1:0]   o_digit_en
);

  localparam int NB_BCD = 4 * NB_DIGITS;
  localparam int NB_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(NB_DATA - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t state, state_next;

  logic [NB_DATA-1:0]   bin_reg, bin_next;
  logic [NB_BCD-1:0]    bcd_reg, bcd_next;
  logic [NB_CNT-1:0]    cnt_reg, cnt_next;
  logic                 sign_reg, sign_next;

  logic                 busy_next, done_next, neg_next;
  logic [NB_BCD-1:0]    obcd_next;
  logic [NB_DIGITS-1:0] en_next;

  logic                 start_sign;
  logic [NB_DATA-1:0]   start_mag;
  logic [NB_BCD-1:0]    bcd_adj, bcd_shift;
  logic [NB_DIGITS-1:0] shift_mask;
  logic                 any_nz;
  logic                 last_shift;

  // The two's complement negation is taken modulo 2**NB_DATA. Because the
  // result is read as unsigned, the most negative input maps to 2**(NB_DATA-1).
  always_comb begin
    start_sign = i_signed & i_data[NB_DATA-1];
    start_mag  = start_sign ? (~i_data + NB_DATA'(1)) : i_data;
  end

  // Add-3 correction: every nibble of 5 or more is bumped before the shift,
  // so the doubling carries correctly into the next decimal digit.
  always_comb begin
    bcd_adj = bcd_reg;
    for (int k = 0; k < NB_DIGITS; k++) begin
      if (bcd_reg[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_reg[4*k +: 4] + 4'd3;
      end
    end
    bcd_shift  = {bcd_adj[NB_BCD-2:0], bin_reg[NB_DATA-1]};
    last_shift = (cnt_reg == LAST_CNT);
  end

  // Leading-zero blanking: scanning from the top digit down, a digit stays
  // lit once any nonzero digit has been seen. The units digit is always lit,
  // so a zero result still shows a single "0".
  always_comb begin
    any_nz     = 1'b0;
    shift_mask = '0;
    for (int k = NB_DIGITS - 1; k >= 0; k--) begin
      any_nz        = any_nz | (bcd_shift[4*k +: 4] != 4'd0);
      shift_mask[k] = any_nz;
    end
    shift_mask[0] = 1'b1;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. While shifting, a request is ignored.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (i_start)    state_next = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Next values for the datapath and the registered outputs. The visible
  // result registers change only on the final shift, and hold otherwise.
  always_comb begin
    bin_next  = bin_reg;
    bcd_next  = bcd_reg;
    cnt_next  = cnt_reg;
    sign_next = sign_reg;
    busy_next = (state_next == ST_SHIFT);
    done_next = 1'b0;
    obcd_next = o_bcd;
    neg_next  = o_neg;
    en_next   = o_digit_en;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          bin_next  = start_mag;
          bcd_next  = '0;
          cnt_next  = '0;
          sign_next = start_sign;
        end
      end
      ST_SHIFT: begin
        bin_next = bin_reg << 1;
        bcd_next = bcd_shift;
        cnt_next = cnt_reg + NB_CNT'(1);
        if (last_shift) begin
          done_next = 1'b1;
          obcd_next = bcd_shift;
          neg_next  = sign_reg;
          en_next   = shift_mask;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers. A reset aborts any conversion in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bin_reg    <= '0;
      bcd_reg    <= '0;
      cnt_reg    <= '0;
      sign_reg   <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_bcd      <= '0;
      o_neg      <= 1'b0;
      o_digit_en <= NB_DIGITS'(1);
    end else begin
      bin_reg    <= bin_next;
      bcd_reg    <= bcd_next;
      cnt_reg    <= cnt_next;
      sign_reg   <= sign_next;
      o_busy     <= busy_next;
      o_done     <= done_next;
      o_bcd      <= obcd_next;
      o_neg      <= neg_next;
      o_digit_en <= en_next;
    end
  end

endmodule
